// File: rtl/nubus_arbiter.sv
// rtl/nubus_arbiter.sv - NuBus distributed arbitration stage; optional fairness via NUBUS_ARB_FAIRNESS_EN
module nubus_arbiter #(
    parameter int unsigned SETTLE_CYC = 2
) (
    input  logic       nub_clkn,
    input  logic       nub_resetn,
    input  logic [3:0] slot_id,
    input  logic       mst_arbcyn,
    input  logic       mst_ownern,
    input  logic       nub_rqstn,
    input  logic       nub_startn,
    input  logic [3:0] nub_arbn,
    output logic       arb_rqstn_o,
    output logic [3:0] arb_arbn_o,
    output logic       arb_grant,
    output logic       arb_busy_o
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARB   = 3'd1,
        ST_LOST  = 3'd2,
        ST_GRANT = 3'd3,
        ST_HOLD  = 3'd4
    } state_t;

    localparam logic [3:0] SETTLE = 4'(SETTLE_CYC);

    state_t     state_q;
    logic [3:0] cnt_q;
    logic       rqstn_q;
    logic       grant_q;
    logic       busy_q;

    logic [3:0] a;
    logic [3:0] drv;
    logic       ko3, ko2, ko1;
    logic       win;
    logic       fair_open;
    logic       driving;

    // Wired-AND contest: a higher bus bit we do not own knocks out all our lower bits
    always_comb begin
        a      = ~nub_arbn;
        ko3    = a[3] & ~slot_id[3];
        ko2    = a[2] & ~slot_id[2];
        ko1    = a[1] & ~slot_id[1];
        drv    = 4'h0;
        drv[3] = slot_id[3];
        drv[2] = slot_id[2] & ~ko3;
        drv[1] = slot_id[1] & ~ko3 & ~ko2;
        drv[0] = slot_id[0] & ~ko3 & ~ko2 & ~ko1;
        win    = (a == slot_id);
    end

    assign driving    = (state_q == ST_ARB) || (state_q == ST_LOST) || (state_q == ST_GRANT);
    assign arb_arbn_o = driving ? ~drv : 4'hF;

`ifdef NUBUS_ARB_FAIRNESS_EN
    logic fair_q;

    // Fair flag: armed when a tenure ends, cleared once the backplane shows no requester
    always_ff @(posedge nub_clkn or negedge nub_resetn) begin
        if (!nub_resetn) begin
            fair_q <= 1'b0;
        end else if ((state_q == ST_HOLD) && mst_arbcyn) begin
            fair_q <= 1'b1;
        end else if (nub_rqstn) begin
            fair_q <= 1'b0;
        end
    end

    assign fair_open = ~fair_q;
`else
    logic unused_rqstn;
    assign unused_rqstn = nub_rqstn;
    assign fair_open    = 1'b1;
`endif

    // Arbitration FSM with registered /RQST, grant and busy
    always_ff @(posedge nub_clkn or negedge nub_resetn) begin
        if (!nub_resetn) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'h0;
            rqstn_q <= 1'b1;
            grant_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!mst_arbcyn && fair_open) begin
                        state_q <= ST_ARB;
                        cnt_q   <= 4'h0;
                        rqstn_q <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                ST_ARB: begin
                    if (mst_arbcyn) begin
                        state_q <= ST_IDLE;
                        rqstn_q <= 1'b1;
                        grant_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end else if (cnt_q == SETTLE) begin
                        if (win) begin
                            state_q <= ST_GRANT;
                            grant_q <= 1'b1;
                        end else begin
                            state_q <= ST_LOST;
                        end
                    end else begin
                        cnt_q <= cnt_q + 4'h1;
                    end
                end
                ST_LOST: begin
                    if (mst_arbcyn) begin
                        state_q <= ST_IDLE;
                        rqstn_q <= 1'b1;
                        grant_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end else if (!nub_startn) begin
                        state_q <= ST_ARB;
                        cnt_q   <= 4'h0;
                    end
                end
                ST_GRANT: begin
                    // A START here without our owner flag belongs to the previous tenure
                    if (mst_arbcyn) begin
                        state_q <= ST_IDLE;
                        rqstn_q <= 1'b1;
                        grant_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end else if (!mst_ownern) begin
                        state_q <= ST_HOLD;
                        rqstn_q <= 1'b1;
                        grant_q <= 1'b0;
                    end
                end
                ST_HOLD: begin
                    if (mst_arbcyn) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    rqstn_q <= 1'b1;
                    grant_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign arb_rqstn_o = rqstn_q;
    assign arb_grant   = grant_q;
    assign arb_busy_o  = busy_q;

endmodule

// File: tb/tb_nubus_arbiter.sv
// tb/tb_nubus_arbiter.sv - directed self-checking bench for nubus_arbiter
`timescale 1ns/1ps
module tb_nubus_arbiter;

    logic       nub_clkn;
    logic       nub_resetn;
    logic [3:0] slot_id;
    logic       mst_arbcyn;
    logic       mst_ownern;
    logic       nub_rqstn;
    logic       nub_startn;
    logic [3:0] nub_arbn;
    logic       arb_rqstn_o;
    logic [3:0] arb_arbn_o;
    logic       arb_grant;
    logic       arb_busy_o;

    int checks = 0;
    int errors = 0;

    nubus_arbiter #(.SETTLE_CYC(2)) dut (
        .nub_clkn    (nub_clkn),
        .nub_resetn  (nub_resetn),
        .slot_id     (slot_id),
        .mst_arbcyn  (mst_arbcyn),
        .mst_ownern  (mst_ownern),
        .nub_rqstn   (nub_rqstn),
        .nub_startn  (nub_startn),
        .nub_arbn    (nub_arbn),
        .arb_rqstn_o (arb_rqstn_o),
        .arb_arbn_o  (arb_arbn_o),
        .arb_grant   (arb_grant),
        .arb_busy_o  (arb_busy_o)
    );

    initial nub_clkn = 1'b0;
    always #5 nub_clkn = ~nub_clkn;

    task automatic step();
        @(posedge nub_clkn);
        #2;
    endtask

    task automatic do_reset(input logic [3:0] id);
        nub_resetn = 1'b0;
        slot_id    = id;
        mst_arbcyn = 1'b1;
        mst_ownern = 1'b1;
        nub_rqstn  = 1'b1;
        nub_startn = 1'b1;
        nub_arbn   = 4'hF;
        step();
        step();
        nub_resetn = 1'b1;
        step();
    endtask

    task automatic test_reset();
        do_reset(4'hA);
        checks++;
        if ({arb_rqstn_o, arb_arbn_o, arb_grant, arb_busy_o} !== 7'b1_1111_0_0) begin
            errors++;
            $display("FAIL reset_outputs: got %b want 1111100", {arb_rqstn_o, arb_arbn_o, arb_grant, arb_busy_o});
        end
    endtask

    task automatic test_solo_win();
        do_reset(4'hA);
        mst_arbcyn = 1'b0;
        step();
        checks++;
        if (arb_rqstn_o !== 1'b0 || arb_arbn_o !== 4'h5 || arb_busy_o !== 1'b1) begin
            errors++;
            $display("FAIL solo_request: rqstn=%b arbn=%h busy=%b want 0 5 1", arb_rqstn_o, arb_arbn_o, arb_busy_o);
        end
        nub_arbn  = 4'h5;
        nub_rqstn = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (arb_grant !== 1'b0) begin
                errors++;
                $display("FAIL solo_early_grant: cycle %0d grant=%b want 0", i, arb_grant);
            end
        end
        step();
        checks++;
        if (arb_grant !== 1'b1 || arb_arbn_o !== 4'h5) begin
            errors++;
            $display("FAIL solo_grant: grant=%b arbn=%h want 1 5", arb_grant, arb_arbn_o);
        end
        mst_ownern = 1'b0;
        step();
        checks++;
        if ({arb_rqstn_o, arb_arbn_o, arb_grant, arb_busy_o} !== 7'b1_1111_0_1) begin
            errors++;
            $display("FAIL solo_release: got %b want 1111101", {arb_rqstn_o, arb_arbn_o, arb_grant, arb_busy_o});
        end
        nub_arbn   = 4'hF;
        nub_rqstn  = 1'b1;
        step();
        checks++;
        if (arb_busy_o !== 1'b1) begin
            errors++;
            $display("FAIL hold_locked: busy=%b want 1", arb_busy_o);
        end
        mst_arbcyn = 1'b1;
        mst_ownern = 1'b1;
        step();
        checks++;
        if (arb_busy_o !== 1'b0 || arb_rqstn_o !== 1'b1) begin
            errors++;
            $display("FAIL hold_exit: busy=%b rqstn=%b want 0 1", arb_busy_o, arb_rqstn_o);
        end
    endtask

    task automatic test_lose_recontest();
        do_reset(4'h3);
        nub_arbn   = 4'h3;
        nub_rqstn  = 1'b0;
        mst_arbcyn = 1'b0;
        step();
        checks++;
        if (arb_rqstn_o !== 1'b0 || arb_arbn_o !== 4'hF) begin
            errors++;
            $display("FAIL lose_collapse: rqstn=%b arbn=%h want 0 f", arb_rqstn_o, arb_arbn_o);
        end
        step();
        step();
        step();
        step();
        checks++;
        if (arb_grant !== 1'b0 || arb_rqstn_o !== 1'b0 || arb_busy_o !== 1'b1 || arb_arbn_o !== 4'hF) begin
            errors++;
            $display("FAIL lost_hold: grant=%b rqstn=%b busy=%b arbn=%h want 0 0 1 f", arb_grant, arb_rqstn_o, arb_busy_o, arb_arbn_o);
        end
        nub_startn = 1'b0;
        step();
        nub_startn = 1'b1;
        nub_arbn   = 4'hF;
        #1;
        checks++;
        if (arb_arbn_o !== 4'hC || arb_grant !== 1'b0) begin
            errors++;
            $display("FAIL recontest_drive: arbn=%h grant=%b want c 0", arb_arbn_o, arb_grant);
        end
        nub_arbn = 4'hC;
        step();
        step();
        checks++;
        if (arb_grant !== 1'b0) begin
            errors++;
            $display("FAIL recontest_early: grant=%b want 0", arb_grant);
        end
        step();
        checks++;
        if (arb_grant !== 1'b1 || arb_arbn_o !== 4'hC) begin
            errors++;
            $display("FAIL recontest_grant: grant=%b arbn=%h want 1 c", arb_grant, arb_arbn_o);
        end
        nub_startn = 1'b0;
        step();
        nub_startn = 1'b1;
        checks++;
        if (arb_grant !== 1'b1) begin
            errors++;
            $display("FAIL stale_start: grant=%b want 1", arb_grant);
        end
        mst_arbcyn = 1'b1;
        step();
        checks++;
        if ({arb_rqstn_o, arb_arbn_o, arb_grant, arb_busy_o} !== 7'b1_1111_0_0) begin
            errors++;
            $display("FAIL grant_abort: got %b want 1111100", {arb_rqstn_o, arb_arbn_o, arb_grant, arb_busy_o});
        end
    endtask

    task automatic test_abort();
        do_reset(4'h5);
        mst_arbcyn = 1'b0;
        step();
        nub_arbn = 4'hA;
        step();
        mst_arbcyn = 1'b1;
        step();
        checks++;
        if ({arb_rqstn_o, arb_arbn_o, arb_grant, arb_busy_o} !== 7'b1_1111_0_0) begin
            errors++;
            $display("FAIL abort_release: got %b want 1111100", {arb_rqstn_o, arb_arbn_o, arb_grant, arb_busy_o});
        end
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (arb_grant !== 1'b0 || arb_busy_o !== 1'b0) begin
                errors++;
                $display("FAIL abort_no_grant: cycle %0d grant=%b busy=%b want 0 0", i, arb_grant, arb_busy_o);
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset(4'h9);
        mst_arbcyn = 1'b0;
        step();
        nub_arbn = 4'h6;
        step();
        step();
        step();
        checks++;
        if (arb_grant !== 1'b1) begin
            errors++;
            $display("FAIL async_pre_grant: grant=%b want 1", arb_grant);
        end
        nub_resetn = 1'b0;
        #1;
        checks++;
        if ({arb_rqstn_o, arb_arbn_o, arb_grant, arb_busy_o} !== 7'b1_1111_0_0) begin
            errors++;
            $display("FAIL async_reset: got %b want 1111100", {arb_rqstn_o, arb_arbn_o, arb_grant, arb_busy_o});
        end
        nub_resetn = 1'b1;
        mst_arbcyn = 1'b1;
        nub_arbn   = 4'hF;
        step();
    endtask

    task automatic test_fairness();
        do_reset(4'hA);
        mst_arbcyn = 1'b0;
        step();
        nub_arbn  = 4'h5;
        nub_rqstn = 1'b0;
        step();
        step();
        step();
        mst_ownern = 1'b0;
        step();
        nub_arbn   = 4'hF;
        mst_arbcyn = 1'b1;
        mst_ownern = 1'b1;
        step();
        checks++;
        if (arb_busy_o !== 1'b0) begin
            errors++;
            $display("FAIL fair_idle: busy=%b want 0", arb_busy_o);
        end
        mst_arbcyn = 1'b0;
`ifdef NUBUS_ARB_FAIRNESS_EN
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (arb_rqstn_o !== 1'b1) begin
                errors++;
                $display("FAIL fair_blocked: cycle %0d rqstn=%b want 1", i, arb_rqstn_o);
            end
        end
        nub_rqstn = 1'b1;
        step();
        nub_rqstn = 1'b0;
        checks++;
        if (arb_rqstn_o !== 1'b1) begin
            errors++;
            $display("FAIL fair_clear_edge: rqstn=%b want 1", arb_rqstn_o);
        end
        step();
        checks++;
        if (arb_rqstn_o !== 1'b0) begin
            errors++;
            $display("FAIL fair_reissue: rqstn=%b want 0", arb_rqstn_o);
        end
`else
        step();
        checks++;
        if (arb_rqstn_o !== 1'b0 || arb_busy_o !== 1'b1) begin
            errors++;
            $display("FAIL immediate_rerequest: rqstn=%b busy=%b want 0 1", arb_rqstn_o, arb_busy_o);
        end
`endif
        mst_arbcyn = 1'b1;
        nub_rqstn  = 1'b1;
        step();
    endtask

    initial begin
        test_reset();
        test_solo_win();
        test_lose_recontest();
        test_abort();
        test_async_reset();
        test_fairness();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/nubus_arbiter.md
Name: nubus_arbiter

Overview:
- NuBus distributed-arbitration stage that sits directly upstream of the master controller.
- Consumes the master's arbitration-cycle request and drives /RQST and the four /ARB lines from the card's slot ID.
- Resolves the wired-AND contest against other cards and returns a registered grant that the master uses to take ownership.
- Releases the bus lines once the master has started its transaction, then enforces NuBus fairness.

Parameters:
- SETTLE_CYC, 2, clocks after entering arbitration before the /ARB lines are sampled for a win decision (1..15).

Ports:
- nub_clkn  input  1  NuBus clock; all state updates on rising edge.
- nub_resetn  input  1  asynchronous active-low reset.
- slot_id  input  4  card ID, active-high, static after reset.
- mst_arbcyn  input  1  arbitration request from master (low = wants bus).
- mst_ownern  input  1  master owner flag (low = master has taken the bus).
- nub_rqstn  input  1  bus /RQST as observed on the backplane.
- nub_startn  input  1  bus /START as observed.
- nub_arbn  input  4  bus /ARB<3:0> as observed (wired-AND).
- arb_rqstn_o  output  1  /RQST drive (low = pull bus low, high = release).
- arb_arbn_o  output  4  /ARB drive per bit (low = pull low, high = release).
- arb_grant  output  1  registered grant to master, active-high.
- arb_busy_o  output  1  high whenever the FSM is not IDLE.

Behaviour:
- Reset (async, nub_resetn low): state IDLE, arb_rqstn_o=1, arb_arbn_o=4'hF, arb_grant=0, arb_busy_o=0, settle counter=0, fair flag clear.
- Contest logic (combinational, used only while driving): a = ~nub_arbn.
  - drv[3]=id[3]
  - drv[2]=id[2] & ~(a[3]&~id[3])
  - drv[1]=id[1] & ~(a[3]&~id[3]) & ~(a[2]&~id[2])
  - drv[0]=id[0] & ~(higher-bit knock-out terms for bits 3..1)
  - arb_arbn_o = ~drv while in ARB/LOST/GRANT, else 4'hF.
- Win = (a == slot_id), evaluated only when the settle counter reaches SETTLE_CYC.
- FSM states: IDLE, ARB, LOST, GRANT, HOLD.
- IDLE -> ARB:
  - Condition: mst_arbcyn low and fair gate open.
  - Assert arb_rqstn_o=0 and drive ARB on the next edge.
  - Clear the counter.
- ARB:
  - Counter increments each clock.
  - At count==SETTLE_CYC: win -> GRANT (arb_grant=1 from the next cycle); else -> LOST.
- LOST:
  - Keep /RQST and the contest drive asserted.
  - On nub_startn low (another winner starting): clear the counter and return to ARB, re-contesting from the following cycle.
- GRANT:
  - arb_grant held high.
  - On mst_ownern low: release /RQST and /ARB, drop arb_grant, and go to HOLD, all on the same edge.
- HOLD: wait for mst_arbcyn high -> IDLE. Locked transactions keep mst_arbcyn low, so HOLD persists until the master releases it.
- Abort: mst_arbcyn high in ARB, LOST or GRANT -> IDLE next edge, all drives released, grant 0.
- A START seen in GRANT with mst_ownern still high is ignored; that START belongs to the previous tenure.
- arb_grant never asserts without the win condition having been true at the settle sample.
- Counter is 4 bits and saturates at SETTLE_CYC; no wrap.
- Reset mid-transaction: all lines released immediately (asynchronous); no glitch-free requirement beyond that.

Optional Feature:
- Macro: NUBUS_ARB_FAIRNESS_EN.
- Defined:
  - Fair flag sets on HOLD -> IDLE.
  - While the flag is set, IDLE ignores mst_arbcyn.
  - Flag clears on the first rising edge where nub_rqstn is sampled high, meaning no contender is requesting.
- Undefined:
  - Fair gate is always open; IDLE re-requests immediately.
  - The flag register is not implemented.

Test Plan:
- Solo win: id=4'hA, no contenders, mst_arbcyn low at t0.
  - -> arb_rqstn_o=0 and arb_arbn_o=4'h5 at t1.
  - -> arb_grant=1 at t1+SETTLE_CYC+1.
  - -> mst_ownern low releases /RQST and /ARB and drops grant on the next edge.
- Lose then re-contest: id=4'h3, bus model drives a=4'hC.
  - -> drv collapses to 4'h0 and FSM enters LOST with /RQST held.
  - -> nub_startn pulse, contender removed.
  - -> re-ARB, then grant after SETTLE_CYC.
- Abort: mst_arbcyn raised in ARB at count 1.
  - -> next edge: IDLE, outputs 1/4'hF, arb_grant never asserted.
- Async reset: nub_resetn low mid-GRANT between clock edges.
  - -> arb_grant=0 and arb_arbn_o=4'hF immediately, with no clock needed.
- Fairness (NUBUS_ARB_FAIRNESS_EN): complete tenure, mst_arbcyn re-asserted while nub_rqstn stays low for 5 cycles.
  - -> arb_rqstn_o stays 1.
  - -> one cycle of nub_rqstn high -> request issued the next edge.
  - Without the macro: request issued the cycle after IDLE.
